// File: rtl/cache_block_responder_pkg.sv
// Shared state encoding and sizing constants for the cache block responder.
// Optional perf counters are enabled by CACHE_RESP_PERF_EN.
package cache_resp_pkg;

   localparam int unsigned BW_WORD_ADDR_DEF = 24;
   localparam int unsigned BW_BLOCK_DEF     = 2;
   localparam int unsigned BW_DATA          = 32;
   localparam int unsigned BW_PERF          = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_FILL  = 3'd1,
      ST_WR_MEM   = 3'd2,
      ST_RD_MEM   = 3'd3,
      ST_RD_DRAIN = 3'd4
   } state_e;

   function automatic int unsigned block_words(input int unsigned bw_block);
      return 32'd1 << bw_block;
   endfunction

endpackage

// File: rtl/cache_block_responder_if.sv
// Cache-side buffer handshake and backing-memory word port of the responder.
// slave = responder view, master = cache/memory (testbench) view.
interface cache_block_responder_if
   import cache_resp_pkg::*;
#(
   parameter int unsigned BW_WORD_ADDR = BW_WORD_ADDR_DEF
);
   logic                    req_i;
   logic                    req_block_i;
   logic                    rw_i;
   logic [BW_WORD_ADDR-1:0] add_i;
   logic                    ready_req_o;
   logic                    ready_write_o;
   logic                    write_i;
   logic [BW_DATA-1:0]      data_i;
   logic                    ready_read_o;
   logic                    read_i;
   logic [BW_DATA-1:0]      data_o;
   logic                    err_o;
   logic                    mem_req_o;
   logic                    mem_rw_o;
   logic [BW_WORD_ADDR-1:0] mem_addr_o;
   logic [BW_DATA-1:0]      mem_wdata_o;
   logic                    mem_ack_i;
   logic [BW_DATA-1:0]      mem_rdata_i;

   modport slave (
      input  req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
             mem_ack_i, mem_rdata_i,
      output ready_req_o, ready_write_o, ready_read_o, data_o, err_o,
             mem_req_o, mem_rw_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
             mem_ack_i, mem_rdata_i,
      input  ready_req_o, ready_write_o, ready_read_o, data_o, err_o,
             mem_req_o, mem_rw_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/cache_block_responder_buffer.sv
// N x 32 block buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module cache_resp_buffer
   import cache_resp_pkg::*;
#(
   parameter int unsigned BW_BLOCK = BW_BLOCK_DEF
) (
   input  logic                clock_i,
   input  logic                wr_en_i,
   input  logic [BW_BLOCK-1:0] wr_idx_i,
   input  logic [BW_DATA-1:0]  wr_data_i,
   input  logic [BW_BLOCK-1:0] rd_idx_i,
   output logic [BW_DATA-1:0]  rd_data_o
);
   localparam int unsigned N = block_words(BW_BLOCK);

   logic [BW_DATA-1:0] mem_q [N];
   logic [BW_DATA-1:0] mem_d [N];

   always_comb begin
      mem_d = mem_q;
      if (wr_en_i) mem_d[wr_idx_i] = wr_data_i;
   end

   always_ff @(posedge clock_i) begin
      mem_q <= mem_d;
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/cache_block_responder.sv
// Cache miss/writeback responder: turns block requests into single-word memory
// transactions through a block buffer. CACHE_RESP_PERF_EN adds perf counters.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | ready for a request; base/length latched on accept
//  ST_WR_FILL  | cache pushes L words into the buffer
//  ST_WR_MEM   | buffered words written to memory, one per mem_ack_i
//  ST_RD_MEM   | words read from memory into the buffer, one per mem_ack_i
//  ST_RD_DRAIN | cache pops L buffered words
module cache_block_responder
   import cache_resp_pkg::*;
#(
   parameter int unsigned BW_WORD_ADDR = BW_WORD_ADDR_DEF,
   parameter int unsigned BW_BLOCK     = BW_BLOCK_DEF
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   cache_block_responder_if.slave   bus
`ifdef CACHE_RESP_PERF_EN
   ,
   output logic [BW_PERF-1:0]       perf_reads_o,
   output logic [BW_PERF-1:0]       perf_writes_o,
   output logic [BW_PERF-1:0]       perf_busy_o
`endif
);
   localparam int unsigned         N          = block_words(BW_BLOCK);
   localparam logic [BW_BLOCK-1:0] LAST_BLOCK = BW_BLOCK'(N - 1);
   localparam logic [BW_BLOCK-1:0] PTR_ONE    = BW_BLOCK'(1);

   state_e                  state_q, state_d;
   logic [BW_WORD_ADDR-1:0] base_q, base_d;
   logic [BW_BLOCK-1:0]     last_q, last_d;
   logic [BW_BLOCK-1:0]     wptr_q, wptr_d;
   logic [BW_BLOCK-1:0]     rptr_q, rptr_d;
   logic [BW_BLOCK-1:0]     k_q, k_d;
   logic                    err_q, err_d;

   logic                    accept;
   logic                    ready_req, ready_wr, ready_rd, mem_req, mem_rw;
   logic                    buf_we;
   logic [BW_BLOCK-1:0]     buf_widx;
   logic [BW_DATA-1:0]      buf_wdata, buf_rdata;
   logic [BW_BLOCK-1:0]     word_off;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      last_d    = last_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      k_d       = k_q;
      err_d     = err_q;
      accept    = 1'b0;
      ready_req = 1'b0;
      ready_wr  = 1'b0;
      ready_rd  = 1'b0;
      mem_req   = 1'b0;
      mem_rw    = 1'b0;
      buf_we    = 1'b0;
      buf_widx  = wptr_q;
      buf_wdata = bus.data_i;
      unique case (state_q)
         ST_IDLE: begin
            ready_req = 1'b1;
            if (bus.req_i) begin
               accept  = 1'b1;
               base_d  = bus.req_block_i ?
                         {bus.add_i[BW_WORD_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}} : bus.add_i;
               last_d  = bus.req_block_i ? LAST_BLOCK : '0;
               wptr_d  = '0;
               rptr_d  = '0;
               k_d     = '0;
               state_d = bus.rw_i ? ST_WR_FILL : ST_RD_MEM;
            end
         end
         ST_WR_FILL: begin
            ready_wr = 1'b1;
            if (bus.write_i) begin
               buf_we = 1'b1;
               wptr_d = wptr_q + PTR_ONE;
               if (wptr_q == last_q) state_d = ST_WR_MEM;
            end
         end
         ST_WR_MEM: begin
            mem_req = 1'b1;
            mem_rw  = 1'b1;
            // rptr follows k here so the single read port also serves mem_wdata_o
            if (bus.mem_ack_i) begin
               k_d    = k_q + PTR_ONE;
               rptr_d = rptr_q + PTR_ONE;
               if (k_q == last_q) state_d = ST_IDLE;
            end
         end
         ST_RD_MEM: begin
            mem_req = 1'b1;
            if (bus.mem_ack_i) begin
               buf_we    = 1'b1;
               buf_widx  = k_q;
               buf_wdata = bus.mem_rdata_i;
               k_d       = k_q + PTR_ONE;
               if (k_q == last_q) state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
            ready_rd = 1'b1;
            if (bus.read_i) begin
               rptr_d = rptr_q + PTR_ONE;
               if (rptr_q == last_q) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((bus.write_i && !ready_wr) || (bus.read_i && !ready_rd)) err_d = 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         last_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         last_q  <= last_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

   cache_resp_buffer #(.BW_BLOCK(BW_BLOCK)) u_buffer (
      .clock_i   (clock_i),
      .wr_en_i   (buf_we),
      .wr_idx_i  (buf_widx),
      .wr_data_i (buf_wdata),
      .rd_idx_i  (rptr_q),
      .rd_data_o (buf_rdata)
   );

   // offset add wraps inside the block, never carries into the tag bits
   assign word_off = base_q[BW_BLOCK-1:0] + k_q;

   assign bus.ready_req_o   = ready_req;
   assign bus.ready_write_o = ready_wr;
   assign bus.ready_read_o  = ready_rd;
   assign bus.data_o        = buf_rdata;
   assign bus.err_o         = err_q;
   assign bus.mem_req_o     = mem_req;
   assign bus.mem_rw_o      = mem_rw;
   assign bus.mem_addr_o    = {base_q[BW_WORD_ADDR-1:BW_BLOCK], word_off};
   assign bus.mem_wdata_o   = buf_rdata;

`ifdef CACHE_RESP_PERF_EN
   logic [BW_PERF-1:0] perf_reads_q, perf_reads_d;
   logic [BW_PERF-1:0] perf_writes_q, perf_writes_d;
   logic [BW_PERF-1:0] perf_busy_q, perf_busy_d;

   always_comb begin
      perf_reads_d  = perf_reads_q;
      perf_writes_d = perf_writes_q;
      perf_busy_d   = perf_busy_q;
      if (accept && !bus.rw_i && perf_reads_q != '1) perf_reads_d = perf_reads_q + BW_PERF'(1);
      if (accept && bus.rw_i && perf_writes_q != '1) perf_writes_d = perf_writes_q + BW_PERF'(1);
      if (state_q != ST_IDLE && perf_busy_q != '1) perf_busy_d = perf_busy_q + BW_PERF'(1);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perf_reads_q  <= '0;
         perf_writes_q <= '0;
         perf_busy_q   <= '0;
      end else begin
         perf_reads_q  <= perf_reads_d;
         perf_writes_q <= perf_writes_d;
         perf_busy_q   <= perf_busy_d;
      end
   end

   assign perf_reads_o  = perf_reads_q;
   assign perf_writes_o = perf_writes_q;
   assign perf_busy_o   = perf_busy_q;
`endif

endmodule
